// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared constants for the instruction cache read-data path
package cache_pkg;

    // Default width of one cache word on the read-data path.
    localparam int READ_WORD_WIDTH = 20;

    // Width of the optional output stall counter.
    localparam int STALL_CNT_W = 16;

endpackage

// File: rtl/arb_src_fifo.sv
// rtl/arb_src_fifo.sv - per-source word FIFO feeding the cache output arbiter
module arb_src_fifo #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 2
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_pop_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    // One extra pointer bit tells full apart from empty when the indices match.
    assign o_full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign o_empty    = (wr_ptr_q == rd_ptr_q);
    assign o_pop_data = mem_q[rd_ptr_q[AW-1:0]];

    // Advance pointers; pushes into a full FIFO and pops from an empty one are ignored.
    always_comb begin
        do_push  = i_push && !o_full;
        do_pop   = i_pop && !o_empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
        end
    end

    // Pointer registers; reset empties the FIFO.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset; the pointers decide what is valid.
    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= i_push_data;
        end
    end

endmodule

// File: rtl/cache_out_arb.sv
// rtl/cache_out_arb.sv - round-robin output arbiter over per-source FIFOs (option: CACHE_OUT_ARB_STALL_CNT_EN)
import cache_pkg::*;

module cache_out_arb #(
    parameter int  WORD_WIDTH = READ_WORD_WIDTH,
    parameter int  NUM_SRC    = 2,
    parameter int  FIFO_DEPTH = 2,
    localparam int SRC_W      = $clog2(NUM_SRC)
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic [NUM_SRC*WORD_WIDTH-1:0] i_src_word,
    input  logic [NUM_SRC-1:0]            i_src_valid,
    output logic [NUM_SRC-1:0]            o_src_ready,
    input  logic                          i_lock_valid,
    input  logic [SRC_W-1:0]              i_lock_src,
    output logic [WORD_WIDTH-1:0]         o_cache_word,
    output logic                          o_cache_word_valid,
    output logic [SRC_W-1:0]              o_cache_src,
    input  logic                          i_cache_word_ready
`ifdef CACHE_OUT_ARB_STALL_CNT_EN
    ,
    output logic [STALL_CNT_W-1:0]        o_stall_count
`endif
);

    logic [NUM_SRC-1:0]    fifo_full;
    logic [NUM_SRC-1:0]    fifo_empty;
    logic [NUM_SRC-1:0]    fifo_pop;
    logic [WORD_WIDTH-1:0] fifo_data [NUM_SRC];

    logic [NUM_SRC-1:0]    elig;
    logic                  grant_found;
    logic [SRC_W-1:0]      grant_src;
    logic [WORD_WIDTH-1:0] grant_word;
    logic                  load;

    logic [SRC_W-1:0]      rr_q, rr_d;
    logic [WORD_WIDTH-1:0] word_q, word_d;
    logic                  valid_q, valid_d;
    logic [SRC_W-1:0]      src_q, src_d;

    // Ready depends only on FIFO state, never on a same-cycle pop.
    assign o_src_ready = ~fifo_full;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        arb_src_fifo #(
            .WIDTH (WORD_WIDTH),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .i_clk       (i_clk),
            .i_reset     (i_reset),
            .i_push      (i_src_valid[g] && !fifo_full[g]),
            .i_push_data (i_src_word[g*WORD_WIDTH +: WORD_WIDTH]),
            .i_pop       (fifo_pop[g]),
            .o_pop_data  (fifo_data[g]),
            .o_full      (fifo_full[g]),
            .o_empty     (fifo_empty[g])
        );
    end

    // Round-robin search from rr upward, wrapping; a lock narrows eligibility to one source.
    always_comb begin
        elig        = '0;
        grant_found = 1'b0;
        grant_src   = '0;
        grant_word  = '0;
        fifo_pop    = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            elig[s] = !fifo_empty[s] && (!i_lock_valid || (i_lock_src == SRC_W'(s)));
        end
        for (int s = 0; s < NUM_SRC; s++) begin
            if (!grant_found && elig[s] && (SRC_W'(s) >= rr_q)) begin
                grant_found = 1'b1;
                grant_src   = SRC_W'(s);
            end
        end
        for (int s = 0; s < NUM_SRC; s++) begin
            if (!grant_found && elig[s]) begin
                grant_found = 1'b1;
                grant_src   = SRC_W'(s);
            end
        end
        load = grant_found && (!valid_q || i_cache_word_ready);
        for (int s = 0; s < NUM_SRC; s++) begin
            if (grant_src == SRC_W'(s)) begin
                grant_word  = fifo_data[s];
                fifo_pop[s] = load;
            end
        end
    end

    // Output register: load on a grant when free, drop valid when consumed, otherwise hold.
    always_comb begin
        rr_d    = rr_q;
        word_d  = word_q;
        valid_d = valid_q;
        src_d   = src_q;
        if (load) begin
            valid_d = 1'b1;
            word_d  = grant_word;
            src_d   = grant_src;
            rr_d    = (grant_src == SRC_W'(NUM_SRC - 1)) ? '0 : grant_src + SRC_W'(1);
        end else if (i_cache_word_ready) begin
            valid_d = 1'b0;
        end
    end

    // Arbiter state registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rr_q    <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
            src_q   <= '0;
        end else begin
            rr_q    <= rr_d;
            word_q  <= word_d;
            valid_q <= valid_d;
            src_q   <= src_d;
        end
    end

    assign o_cache_word       = word_q;
    assign o_cache_word_valid = valid_q;
    assign o_cache_src        = src_q;

`ifdef CACHE_OUT_ARB_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Count cycles where a word waits on the fetch unit, saturating at all ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (valid_q && !i_cache_word_ready && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
        end
    end

    // Stall counter register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign o_stall_count = stall_cnt_q;
`endif

endmodule
